mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control sequencer for the 32-bit datapath. It runs a fetch/decode/execute state machine over the opcode held in the instruction register. Each cycle it drives the clock-enable strobes of the datapath's REG32 registers (PC, IR, MDR) plus the register-file, memory and mux selects. It sits beside the datapath and is its only source of `CE` and write-enable signals.

## Interface
- No parameters; opcode and state encodings are fixed constants.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `opcode` in 6: IR[31:26]; sampled in DECODE only.
- `zero` in 1: ALU zero flag; used in BRANCH only.
- `mem_ready` in 1: memory handshake; present only with `MC_CTRL_WAIT_EN`.
- `pc_ce`, `ir_ce`, `mdr_ce` out 1: CE of PC, IR and MDR registers.
- `reg_we` out 1: register-file write enable.
- `mem_rd`, `mem_wr` out 1: memory read and write strobes.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 0 = B, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2.
- `alu_op` out 2: 0 = add, 1 = sub, 2 = funct-decoded.
- `pc_src` out 2: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- `reg_dst` out 1: 0 = rt, 1 = rd.
- `mem_to_reg` out 1: 0 = ALUOut, 1 = MDR.
- `state` out 4: current state, for debug.
- `illegal` out 1: one-cycle pulse on an unknown opcode.

## Operation
- Supported opcodes: R-type 0x00, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02, ADDI 0x08.
- State codes:
  - FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5.
  - EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11.
- FETCH: `mem_rd`=1, `iord`=0, `ir_ce`=1, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=0, `pc_src`=0, `pc_ce`=1 (PC+4). Next state: DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=3, `alu_op`=0 (branch target into ALUOut). Next state by opcode:
  - LW or SW → MEM_ADDR; R-type → EXEC; BEQ → BRANCH; J → JUMP; ADDI → ADDI_EX.
  - Any other opcode → FETCH with `illegal`=1 for that one cycle.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0. Next: MEM_RD for LW, MEM_WR for SW.
- MEM_RD: `mem_rd`=1, `iord`=1, `mdr_ce`=1. Next: MEM_WB.
- MEM_WB: `reg_we`=1, `reg_dst`=0, `mem_to_reg`=1. Next: FETCH.
- MEM_WR: `mem_wr`=1, `iord`=1. Next: FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2. Next: R_WB.
- R_WB: `reg_we`=1, `reg_dst`=1, `mem_to_reg`=0. Next: FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=1, `pc_src`=1, `pc_ce`=`zero` (Mealy output). Next: FETCH.
- JUMP: `pc_src`=2, `pc_ce`=1. Next: FETCH.
- ADDI_EX: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0. Next: ADDI_WB.
- ADDI_WB: `reg_we`=1, `reg_dst`=0, `mem_to_reg`=0. Next: FETCH.
- Any select not listed for a state is 0. Every enable and strobe not listed is 0.
- Unused state codes 12–15 → FETCH on the next edge. All enables are 0 while in them.

## Timing
- State register updates on the rising `clk` edge. All outputs are combinational from `state`; `pc_ce` in BRANCH also depends on `zero`.
- Cycles per instruction, without waits: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Reset:
  - `rst`=1 at an edge sets `state` to FETCH (0).
  - While `rst`=1, all CE, write and strobe outputs are forced to 0 and `illegal`=0.
  - The first cycle after `rst` deasserts is a live FETCH.
- Reset in mid-instruction abandons it. No partial write occurs after that edge.
- `opcode` is sampled only in DECODE; it may change in any other state without effect.

## Configuration
- `MC_CTRL_WAIT_EN` defined:
  - The `mem_ready` port exists.
  - FETCH, MEM_RD and MEM_WR hold while `mem_ready`=0, keeping `mem_rd`/`mem_wr` asserted and `iord` stable.
  - `pc_ce`, `ir_ce` and `mdr_ce` assert only in the cycle where `mem_ready`=1; the state advances on that edge.
- `MC_CTRL_WAIT_EN` undefined: no `mem_ready` port, and every memory state lasts exactly one cycle.

## Structure
- Package `mc_ctrl_pkg` holds:
  - State codes, opcode constants, and the `alu_op`, `alu_src_b` and `pc_src` encodings.
- One sub-module, `mc_ctrl_decode`: a combinational decoder mapping `state`, `zero` and `mem_ready` to all control outputs.
- `mc_ctrl` keeps only the state register and next-state logic.

## Test plan
- Reset, then `opcode`=0x23 (LW), no waits → state sequence 0,1,2,3,4,0.
  - `ir_ce`=1 in cycle 0 only, `mdr_ce`=1 in cycle 3 only, `reg_we`=1 with `mem_to_reg`=1 in cycle 4.
- `opcode`=0x04 (BEQ) with `zero`=1, then again with `zero`=0 → states 0,1,8.
  - `pc_ce`=1 with `pc_src`=1 in state 8 on the first run; `pc_ce`=0 in state 8 on the second.
- `opcode`=0x3F → states 0,1,0 with `illegal`=1 exactly in the DECODE cycle; no `reg_we` or `mem_wr` asserted.
- `rst` asserted in MEM_WR of an SW → `mem_wr` low from that cycle on; `state`=0 after the edge; a clean FETCH follows.
- R-type, then ADDI, then J, back to back → 4+4+3 = 11 cycles total.
  - `reg_dst`=1 in the R_WB cycle, `reg_dst`=0 in the ADDI_WB cycle, `pc_src`=2 in JUMP.
- With `MC_CTRL_WAIT_EN`, `mem_ready` held low 3 cycles in FETCH → state stays 0 for 4 cycles, `mem_rd` held high, `ir_ce` and `pc_ce` assert in the 4th cycle only.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer.
// Latency: n/a (constants, types and one pure helper function only).
// Backpressure: n/a.
//
// Holds the FSM state codes, the supported opcodes and the encodings
// driven onto the datapath mux selects (alu_op, alu_src_b, pc_src).
// The state codes are visible on the debug port, so their values are fixed.
package mc_ctrl_pkg;

    // Sequencer states. Codes 12..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_e;

    // Opcodes taken from IR[31:26].
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU operation select.
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    // ALU B-operand select.
    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    // PC source select.
    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    // True for every opcode the sequencer knows how to execute.
    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decoder: maps the sequencer state to datapath controls.
// Latency: zero cycles (pure combinational from state_i, zero_i, mem_ready_i).
// Backpressure: with MC_CTRL_WAIT_EN, CE strobes of memory states wait for mem_ready_i.
//
// Ports:
//   state_i      current sequencer state code
//   zero_i       ALU zero flag; only used to qualify the branch PC update
//   mem_ready_i  memory handshake (present only when MC_CTRL_WAIT_EN is defined)
//   *_o          control outputs, same meaning as the identically named
//                mc_ctrl ports; reset gating is applied by the parent.
//
// Every select and enable defaults to 0, so each state only lists what it
// drives. Unused state codes fall through to the all-zero default.
module mc_ctrl_decode (
    input  logic [3:0] state_i,
    input  logic       zero_i,
`ifdef MC_CTRL_WAIT_EN
    input  logic       mem_ready_i,
`endif
    output logic       pc_ce_o,
    output logic       ir_ce_o,
    output logic       mdr_ce_o,
    output logic       reg_we_o,
    output logic       mem_rd_o,
    output logic       mem_wr_o,
    output logic       iord_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_src_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o
);
    import mc_ctrl_pkg::*;

    // Memory completion qualifier. Without the wait feature every memory
    // access completes in its first cycle.
    logic mem_done;
`ifdef MC_CTRL_WAIT_EN
    assign mem_done = mem_ready_i;
`else
    assign mem_done = 1'b1;
`endif

    always_comb begin
        pc_ce_o      = 1'b0;
        ir_ce_o      = 1'b0;
        mdr_ce_o     = 1'b0;
        reg_we_o     = 1'b0;
        mem_rd_o     = 1'b0;
        mem_wr_o     = 1'b0;
        iord_o       = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_B;
        alu_op_o     = ALU_ADD;
        pc_src_o     = PC_ALU;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;

        case (state_i)
            S_FETCH: begin
                // Instruction read from PC; PC+4 computed and written back
                // in the same cycle, but only once the read has completed.
                mem_rd_o    = 1'b1;
                iord_o      = 1'b0;
                ir_ce_o     = mem_done;
                pc_ce_o     = mem_done;
                alu_src_a_o = 1'b0;
                alu_src_b_o = SRCB_FOUR;
                alu_op_o    = ALU_ADD;
                pc_src_o    = PC_ALU;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_a_o = 1'b0;
                alu_src_b_o = SRCB_IMM_SH2;
                alu_op_o    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_rd_o = 1'b1;
                iord_o   = 1'b1;
                mdr_ce_o = mem_done;
            end
            S_MEM_WB: begin
                reg_we_o     = 1'b1;
                reg_dst_o    = 1'b0;
                mem_to_reg_o = 1'b1;
            end
            S_MEM_WR: begin
                mem_wr_o = 1'b1;
                iord_o   = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_B;
                alu_op_o    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_we_o     = 1'b1;
                reg_dst_o    = 1'b1;
                mem_to_reg_o = 1'b0;
            end
            S_BRANCH: begin
                // Compare A-B; the PC takes the precomputed target from
                // ALUOut only when the operands were equal.
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_B;
                alu_op_o    = ALU_SUB;
                pc_src_o    = PC_ALUOUT;
                pc_ce_o     = zero_i;
            end
            S_JUMP: begin
                pc_src_o = PC_JUMP;
                pc_ce_o  = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALU_ADD;
            end
            S_ADDI_WB: begin
                reg_we_o     = 1'b1;
                reg_dst_o    = 1'b0;
                mem_to_reg_o = 1'b0;
            end
            default: begin
                // Unused codes: everything stays at its inactive default.
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer; sole source of datapath CE/write strobes.
// Latency: outputs are combinational from the state register (pc_ce in BRANCH also from zero).
// Backpressure: with MC_CTRL_WAIT_EN, FETCH/MEM_RD/MEM_WR hold until mem_ready is high.
//
// Ports:
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   opcode              IR[31:26], looked at in DECODE only
//   zero                ALU zero flag, used in BRANCH only
//   mem_ready           memory handshake, present only with MC_CTRL_WAIT_EN
//   pc_ce/ir_ce/mdr_ce  clock enables of the PC, IR and MDR registers
//   reg_we              register-file write enable
//   mem_rd/mem_wr       memory strobes; iord selects the address (0 PC, 1 ALUOut)
//   alu_src_a/alu_src_b/alu_op/pc_src/reg_dst/mem_to_reg   datapath selects
//   state               current state code for debug
//   illegal             one-cycle pulse in DECODE when the opcode is unknown
//
// Optional feature macro: MC_CTRL_WAIT_EN (memory wait states via mem_ready).
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
`ifdef MC_CTRL_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       pc_ce,
    output logic       ir_ce,
    output logic       mdr_ce,
    output logic       reg_we,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       iord,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [3:0] state,
    output logic       illegal
);
    import mc_ctrl_pkg::*;

    state_e state_q, state_d;

    // Load/store distinction captured in DECODE, so MEM_ADDR can branch to
    // MEM_RD or MEM_WR even though opcode may have changed by then.
    logic is_load_q, is_load_d;

    // Memory completion qualifier for the states that touch memory.
    logic mem_done;
`ifdef MC_CTRL_WAIT_EN
    assign mem_done = mem_ready;
`else
    assign mem_done = 1'b1;
`endif

    // Raw decoder outputs before reset gating.
    logic       dec_pc_ce;
    logic       dec_ir_ce;
    logic       dec_mdr_ce;
    logic       dec_reg_we;
    logic       dec_mem_rd;
    logic       dec_mem_wr;
    logic       dec_iord;
    logic       dec_alu_src_a;
    logic [1:0] dec_alu_src_b;
    logic [1:0] dec_alu_op;
    logic [1:0] dec_pc_src;
    logic       dec_reg_dst;
    logic       dec_mem_to_reg;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;

        case (state_q)
            S_FETCH: begin
                if (mem_done) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                is_load_d = (opcode == OP_LW);
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = is_load_q ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_done) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB:  state_d = S_FETCH;
            S_MEM_WR: begin
                if (mem_done) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC:    state_d = S_R_WB;
            S_R_WB:    state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_ADDI_WB: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // ---------------------------------------------------------------
    // Output logic: state decoder plus reset gating
    // ---------------------------------------------------------------
    mc_ctrl_decode u_decode (
        .state_i      (state_q),
        .zero_i       (zero),
`ifdef MC_CTRL_WAIT_EN
        .mem_ready_i  (mem_ready),
`endif
        .pc_ce_o      (dec_pc_ce),
        .ir_ce_o      (dec_ir_ce),
        .mdr_ce_o     (dec_mdr_ce),
        .reg_we_o     (dec_reg_we),
        .mem_rd_o     (dec_mem_rd),
        .mem_wr_o     (dec_mem_wr),
        .iord_o       (dec_iord),
        .alu_src_a_o  (dec_alu_src_a),
        .alu_src_b_o  (dec_alu_src_b),
        .alu_op_o     (dec_alu_op),
        .pc_src_o     (dec_pc_src),
        .reg_dst_o    (dec_reg_dst),
        .mem_to_reg_o (dec_mem_to_reg)
    );

    always_comb begin
        // Enables and strobes are killed combinationally by rst so that a
        // reset landing mid-instruction cannot complete a write in that cycle.
        pc_ce      = dec_pc_ce  & ~rst;
        ir_ce      = dec_ir_ce  & ~rst;
        mdr_ce     = dec_mdr_ce & ~rst;
        reg_we     = dec_reg_we & ~rst;
        mem_rd     = dec_mem_rd & ~rst;
        mem_wr     = dec_mem_wr & ~rst;
        illegal    = ~rst & (state_q == S_DECODE) & ~op_is_legal(opcode);

        // Selects are harmless without an enable and pass straight through.
        iord       = dec_iord;
        alu_src_a  = dec_alu_src_a;
        alu_src_b  = dec_alu_src_b;
        alu_op     = dec_alu_op;
        pc_src     = dec_pc_src;
        reg_dst    = dec_reg_dst;
        mem_to_reg = dec_mem_to_reg;
        state      = state_q;
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl: instruction-level reference model plus directed vectors.
module tb_mc_ctrl;

`ifdef MC_CTRL_WAIT_EN
    localparam bit WAIT_BUILD = 1'b1;
`else
    localparam bit WAIT_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic       pc_ce, ir_ce, mdr_ce, reg_we, mem_rd, mem_wr, iord, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       reg_dst, mem_to_reg, illegal;
    logic [3:0] state;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
`ifdef MC_CTRL_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .pc_ce      (pc_ce),
        .ir_ce      (ir_ce),
        .mdr_ce     (mdr_ce),
        .reg_we     (reg_we),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .iord       (iord),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .state      (state),
        .illegal    (illegal)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       pc_ce, ir_ce, mdr_ce, reg_we, mem_rd, mem_wr, iord, src_a;
        logic [1:0] src_b, alu_op, pc_src;
        logic       reg_dst, m2r, illegal;
    } outs_t;

    // ---------------------------------------------------------------
    // Reference model: tracks the instruction path as a queue of the
    // states still to be visited, and derives outputs from a per-state
    // table of the listed assignments.
    // ---------------------------------------------------------------
    int m_state = 0;
    int m_path[$];

    function automatic logic known_op(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
               (op == 6'h04) || (op == 6'h02) || (op == 6'h08);
    endfunction

    function automatic outs_t model_out(input int st, input logic z, input logic rdy,
                                        input logic r, input logic [5:0] op);
        outs_t e;
        e = '0;
        case (st)
            0:  begin e.mem_rd = 1; e.ir_ce = rdy; e.pc_ce = rdy; e.src_b = 2'd1; end
            1:  begin e.src_b = 2'd3; e.illegal = !known_op(op); end
            2:  begin e.src_a = 1; e.src_b = 2'd2; end
            3:  begin e.mem_rd = 1; e.iord = 1; e.mdr_ce = rdy; end
            4:  begin e.reg_we = 1; e.m2r = 1; end
            5:  begin e.mem_wr = 1; e.iord = 1; end
            6:  begin e.src_a = 1; e.alu_op = 2'd2; end
            7:  begin e.reg_we = 1; e.reg_dst = 1; end
            8:  begin e.src_a = 1; e.alu_op = 2'd1; e.pc_src = 2'd1; e.pc_ce = z; end
            9:  begin e.pc_src = 2'd2; e.pc_ce = 1; end
            10: begin e.src_a = 1; e.src_b = 2'd2; end
            11: begin e.reg_we = 1; end
            default: e = '0;
        endcase
        if (r) begin
            e.pc_ce = 0; e.ir_ce = 0; e.mdr_ce = 0; e.reg_we = 0;
            e.mem_rd = 0; e.mem_wr = 0; e.illegal = 0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0;
            m_path.delete();
        end else if (WAIT_BUILD && !mem_ready && (m_state == 0 || m_state == 3 || m_state == 5)) begin
            m_state = m_state;
        end else if (m_state == 0) begin
            m_state = 1;
        end else begin
            if (m_state == 1) begin
                case (opcode)
                    6'h23:   m_path = '{2, 3, 4};
                    6'h2B:   m_path = '{2, 5};
                    6'h00:   m_path = '{6, 7};
                    6'h04:   m_path = '{8};
                    6'h02:   m_path = '{9};
                    6'h08:   m_path = '{10, 11};
                    default: m_path.delete();
                endcase
            end
            m_state = (m_path.size() > 0) ? m_path.pop_front() : 0;
        end
    end

    // Single compare process: every cycle, on the falling edge.
    always @(negedge clk) begin : cmp
        outs_t a, e;
        a = '{pc_ce, ir_ce, mdr_ce, reg_we, mem_rd, mem_wr, iord, alu_src_a,
              alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg, illegal};
        e = model_out(m_state, zero, WAIT_BUILD ? mem_ready : 1'b1, rst, opcode);
        n_cmp++;
        if (state !== m_state[3:0]) begin
            n_bad++;
            $display("FAIL model_state t=%0t: got %0d want %0d", $time, state, m_state);
        end
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL model_outputs t=%0t state=%0d: got %h want %h", $time, m_state, a, e);
        end
    end

    // ---------------------------------------------------------------
    // Per-cycle trace for the literal expectations
    // ---------------------------------------------------------------
    logic [3:0] tr_st    [64];
    logic       tr_ir    [64];
    logic       tr_pc    [64];
    logic       tr_mdr   [64];
    logic       tr_we    [64];
    logic       tr_m2r   [64];
    logic       tr_rd    [64];
    logic       tr_wr    [64];
    logic       tr_ill   [64];
    logic       tr_dst   [64];
    logic [1:0] tr_pcsrc [64];
    int tix = 0;

    logic [3:0] lw_seq  [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [3:0] ill_seq [3] = '{4'd0, 4'd1, 4'd0};

    task automatic cycle();
        @(negedge clk);
        tr_st[tix]    = state;
        tr_ir[tix]    = ir_ce;
        tr_pc[tix]    = pc_ce;
        tr_mdr[tix]   = mdr_ce;
        tr_we[tix]    = reg_we;
        tr_m2r[tix]   = mem_to_reg;
        tr_rd[tix]    = mem_rd;
        tr_wr[tix]    = mem_wr;
        tr_ill[tix]   = illegal;
        tr_dst[tix]   = reg_dst;
        tr_pcsrc[tix] = pc_src;
        tix++;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic run(input logic [5:0] op, input logic z, input int n);
        opcode = op;
        zero   = z;
        repeat (n) cycle();
    endtask

    initial begin
        // Reset for two cycles.
        rst = 1'b1;
        cycle();
        cycle();
        check("reset_state", {28'd0, tr_st[1]}, 32'd0);
        check("reset_enables", {25'd0, tr_pc[1], tr_ir[1], tr_mdr[1], tr_we[1],
                                tr_rd[1], tr_wr[1], tr_ill[1]}, 32'd0);

        rst = 1'b0;
        tix = 0;
        // LW (0..4); opcode scrambled after DECODE must not matter.
        run(6'h23, 1'b0, 2);
        run(6'h3F, 1'b0, 3);
        // BEQ taken (5..7), BEQ not taken (8..10).
        run(6'h04, 1'b1, 3);
        run(6'h04, 1'b0, 3);
        // Illegal opcode (11..12).
        run(6'h3F, 1'b0, 2);
        // SW (13..15), reset landing in MEM_WR (16).
        run(6'h2B, 1'b0, 3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        // R-type (17..20), ADDI (21..24), J (25..27), next fetch (28).
        run(6'h00, 1'b1, 4);
        run(6'h08, 1'b0, 4);
        run(6'h02, 1'b0, 3);
        run(6'h23, 1'b0, 1);

        for (int i = 0; i < 6; i++) check($sformatf("lw_state[%0d]", i), {28'd0, tr_st[i]}, {28'd0, lw_seq[i]});
        for (int i = 0; i < 5; i++) begin
            check($sformatf("lw_ir_ce[%0d]", i), {31'd0, tr_ir[i]}, (i == 0) ? 32'd1 : 32'd0);
            check($sformatf("lw_mdr_ce[%0d]", i), {31'd0, tr_mdr[i]}, (i == 3) ? 32'd1 : 32'd0);
        end
        check("lw_reg_we_c4", {31'd0, tr_we[4]}, 32'd1);
        check("lw_mem_to_reg_c4", {31'd0, tr_m2r[4]}, 32'd1);

        check("beq1_state", {28'd0, tr_st[7]}, 32'd8);
        check("beq1_pc_ce", {31'd0, tr_pc[7]}, 32'd1);
        check("beq1_pc_src", {30'd0, tr_pcsrc[7]}, 32'd1);
        check("beq0_state", {28'd0, tr_st[10]}, 32'd8);
        check("beq0_pc_ce", {31'd0, tr_pc[10]}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("ill_state[%0d]", i), {28'd0, tr_st[11 + i]}, {28'd0, ill_seq[i]});
            check($sformatf("ill_pulse[%0d]", i), {31'd0, tr_ill[11 + i]}, (i == 1) ? 32'd1 : 32'd0);
        end
        check("ill_no_write", {30'd0, tr_we[11] | tr_we[12], tr_wr[11] | tr_wr[12]}, 32'd0);

        check("sw_rst_state", {28'd0, tr_st[16]}, 32'd5);
        check("sw_rst_mem_wr", {31'd0, tr_wr[16]}, 32'd0);
        check("post_rst_state", {28'd0, tr_st[17]}, 32'd0);
        check("post_rst_fetch", {30'd0, tr_rd[17], tr_ir[17]}, 32'd3);

        begin
            int i, nf;
            i = 17;
            nf = 0;
            while (i < tix) begin
                if (tr_st[i] == 4'd0) nf++;
                if (nf == 4) break;
                i++;
            end
            check("r_addi_j_cycles", i - 17, 32'd11);
        end
        check("rwb_state", {28'd0, tr_st[20]}, 32'd7);
        check("rwb_reg_dst", {31'd0, tr_dst[20]}, 32'd1);
        check("addiwb_state", {28'd0, tr_st[24]}, 32'd11);
        check("addiwb_reg_dst", {31'd0, tr_dst[24]}, 32'd0);
        check("jump_state", {28'd0, tr_st[27]}, 32'd9);
        check("jump_pc_src", {30'd0, tr_pcsrc[27]}, 32'd2);

`ifdef MC_CTRL_WAIT_EN
        // FETCH held three cycles by mem_ready, then a stalled MEM_RD.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        mem_ready = 1'b0;
        tix = 40;
        run(6'h23, 1'b0, 3);
        mem_ready = 1'b1;
        run(6'h23, 1'b0, 3);
        mem_ready = 1'b0;
        run(6'h23, 1'b0, 2);
        mem_ready = 1'b1;
        run(6'h23, 1'b0, 2);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wait_state[%0d]", i), {28'd0, tr_st[40 + i]}, 32'd0);
            check($sformatf("wait_mem_rd[%0d]", i), {31'd0, tr_rd[40 + i]}, 32'd1);
            check($sformatf("wait_ir_ce[%0d]", i), {31'd0, tr_ir[40 + i]}, (i == 3) ? 32'd1 : 32'd0);
            check($sformatf("wait_pc_ce[%0d]", i), {31'd0, tr_pc[40 + i]}, (i == 3) ? 32'd1 : 32'd0);
        end
        check("wait_decode", {28'd0, tr_st[44]}, 32'd1);
        check("wait_mdr_hold", {27'd0, tr_st[46], tr_mdr[46]}, 32'd6);
        check("wait_mdr_go", {27'd0, tr_st[48], tr_mdr[48]}, 32'd7);
        check("wait_memwb", {28'd0, tr_st[49]}, 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
